rv_muldiv: RTL and testbench
============================

RV_MULDIV -- requirements
Module: rv_muldiv

Interface
REQ-001 Parameter XLEN, default 32, sets operand/result width; legal values 8..64, power of two.
REQ-002 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port reset  input  1  asynchronous, active-high reset.
REQ-004 Port in_valid  input  1  request present.
REQ-005 Port in_ready  output  1  unit can accept; high only in IDLE.
REQ-006 Port in_op  input  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-007 Port in_rd  input  5  destination register tag, returned unchanged.
REQ-008 Port in_s1  input  XLEN  operand 1 (multiplicand/dividend).
REQ-009 Port in_s2  input  XLEN  operand 2 (multiplier/divisor).
REQ-010 Port flush  input  1  synchronous abort of in-flight operation.
REQ-011 Port out_valid  output  1  result present.
REQ-012 Port out_ready  input  1  consumer accepts result.
REQ-013 Port out_rd  output  5  tag of returned result.
REQ-014 Port out_d  output  XLEN  result.
REQ-015 Port busy  output  1  high in any state other than IDLE.

Function
REQ-016 FSM states SHALL be IDLE, CALC, FIX, DONE.
REQ-017 Accept occurs on an edge where in_valid && in_ready && !flush; op, rd, operands latched.
REQ-018 MUL/MULH/MULHSU/MULHU: operands converted to magnitudes per signedness (MULH both signed, MULHSU s1 signed only, MULHU/MUL unsigned treatment acceptable for MUL); 2*XLEN-bit shift-add product, one multiplier bit per CALC cycle.
REQ-019 DIV/DIVU/REM/REMU: restoring division on magnitudes, one quotient bit per CALC cycle.
REQ-020 CALC lasts exactly XLEN cycles, counted by a $clog2(XLEN)+1-bit counter; then FIX.
REQ-021 FIX applies sign: product negated if operand signs differ (signed ops); quotient negated if signs differ; remainder takes dividend sign; selects low half (MUL), high half (MULH*), quotient or remainder; then DONE.
REQ-022 Normal latency: out_valid high after XLEN+2 rising edges counted from the accepting edge (accept->CALC, XLEN steps, FIX->DONE).
REQ-023 Fast path, decided at accept, entering DONE directly (out_valid high after 1 edge): divisor zero -> quotient all ones, remainder = dividend; signed DIV/REM of -2^(XLEN-1) by -1 -> quotient = dividend, remainder 0.
REQ-024 In DONE, out_valid=1; out_d, out_rd held stable until out_valid && out_ready, then IDLE on that edge.
REQ-025 in_ready=0 in CALC, FIX, DONE; no overlap; next accept earliest one edge after result handshake.
REQ-026 flush has priority over accept and handshake: any state -> IDLE next edge, out_valid 0, no result emitted.
REQ-027 rd=0 requests processed normally; discarding is caller's job.
REQ-028 All arithmetic modulo 2^XLEN for out_d; no exceptions raised.

Reset
REQ-029 reset asserted: immediately (no clock) state IDLE, out_valid 0, busy 0, out_d 0, out_rd 0, counter 0; in_ready 1 once reset deasserted.
REQ-030 reset mid-operation discards in-flight result; no out_valid after release.

Verification (XLEN=32 unless stated)
REQ-031 MUL 7 * 0xFFFFFFFD -> out_d 0xFFFFFFEB, out_valid exactly 34 edges after accept.
REQ-032 MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
REQ-033 DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-034 DIV 5/0 -> 0xFFFFFFFF, REM 5/0 -> 5, DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0; each out_valid 1 edge after accept.
REQ-035 out_ready held low 10 cycles in DONE -> out_valid, out_d, out_rd stable, in_ready 0; handshake -> IDLE, new accept on following edge.
REQ-036 flush 5 cycles into CALC -> no out_valid, in_ready 1 next cycle; async reset mid-CALC -> out_valid/busy 0 without clock edge; repeat REQ-031..033 at XLEN=16 against reference model.

Source files
------------

// File: rtl/rv_muldiv.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring-divide step per
// CALC cycle, sign fix-up in FIX, result held in DONE until the consumer takes it.
module rv_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_op,
  input  logic [4:0]      in_rd,
  input  logic [XLEN-1:0] in_s1,
  input  logic [XLEN-1:0] in_s2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_d,
  output logic            busy
);

  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [4:0]          rd_q, rd_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     b_q, b_d;
  logic [XLEN-1:0]     res_q, res_d;
  logic                sa_q, sa_d, sb_q, sb_d;

  // accept-time operand decode
  logic            acc_en, is_div, s1_sgn, s2_sgn, a_neg, b_neg, div0, ovf;
  logic [XLEN-1:0] a_mag, b_mag, fast_res;

  always_comb begin
    acc_en   = in_valid && (state_q == IDLE) && !flush;
    is_div   = in_op[2];
    s1_sgn   = (in_op == 3'd1) || (in_op == 3'd2) || (is_div && !in_op[0]);
    s2_sgn   = (in_op == 3'd1) || (is_div && !in_op[0]);
    a_neg    = s1_sgn && in_s1[XLEN-1];
    b_neg    = s2_sgn && in_s2[XLEN-1];
    a_mag    = a_neg ? -in_s1 : in_s1;
    b_mag    = b_neg ? -in_s2 : in_s2;
    div0     = is_div && (in_s2 == '0);
    ovf      = is_div && !in_op[0] && (in_s1 == {1'b1, {(XLEN-1){1'b0}}}) && (&in_s2);
    fast_res = div0 ? (in_op[1] ? in_s1 : '1) : (in_op[1] ? '0 : in_s1);
  end

  // one iteration step; acc holds {hi, lo} = {partial product, multiplier}
  // for multiply and {remainder, quotient/dividend} for divide
  logic [XLEN:0]     mul_sum, div_sh, div_trial;
  logic [2*XLEN-1:0] mul_nxt, div_nxt;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
    mul_nxt   = {mul_sum, acc_q[XLEN-1:1]};
    div_sh    = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_trial = div_sh - {1'b0, b_q};
    if (!div_trial[XLEN])
      div_nxt = {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    else
      div_nxt = {div_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
  end

  // sign fix-up and result select
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, fix_res;

  always_comb begin
    prod = (sa_q ^ sb_q) ? -acc_q : acc_q;
    quo  = (sa_q ^ sb_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem  = sa_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    if (op_q[2])
      fix_res = op_q[1] ? rem : quo;
    else
      fix_res = (op_q == 3'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    b_d     = b_q;
    res_d   = res_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: if (acc_en) begin
          op_d  = in_op;
          rd_d  = in_rd;
          sa_d  = a_neg;
          sb_d  = b_neg;
          cnt_d = '0;
          acc_d = {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
          b_d   = is_div ? b_mag : a_mag;
          if (div0 || ovf) begin
            res_d   = fast_res;
            state_d = DONE;
          end else begin
            state_d = CALC;
          end
        end
        CALC: begin
          acc_d = op_q[2] ? div_nxt : mul_nxt;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(XLEN - 1)) begin
            state_d = FIX;
            cnt_d   = '0;
          end
        end
        FIX: begin
          res_d   = fix_res;
          state_d = DONE;
        end
        DONE: if (out_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign out_d     = res_q;
  assign out_rd    = rd_q;

endmodule

// File: tb/tb_rv_muldiv.sv
// Directed bench for rv_muldiv: XLEN=32 instance against hand-computed vectors,
// XLEN=16 instance against a behavioural reference model.
module tb_rv_muldiv;

  logic clk, reset;

  logic        a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready, a_busy;
  logic [2:0]  a_in_op;
  logic [4:0]  a_in_rd, a_out_rd;
  logic [31:0] a_in_s1, a_in_s2, a_out_d;

  logic        b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready, b_busy;
  logic [2:0]  b_in_op;
  logic [4:0]  b_in_rd, b_out_rd;
  logic [15:0] b_in_s1, b_in_s2, b_out_d;

  int n_cmp = 0;
  int n_bad = 0;

  rv_muldiv #(.XLEN(32)) u32 (
    .clk(clk), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_op(a_in_op), .in_rd(a_in_rd), .in_s1(a_in_s1), .in_s2(a_in_s2),
    .flush(a_flush), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_rd(a_out_rd), .out_d(a_out_d), .busy(a_busy)
  );

  rv_muldiv #(.XLEN(16)) u16 (
    .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_op(b_in_op), .in_rd(b_in_rd), .in_s1(b_in_s1), .in_s2(b_in_s2),
    .flush(b_flush), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_rd(b_out_rd), .out_d(b_out_d), .busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- drivers ----------------
  task automatic start32(input logic [2:0] op, input logic [31:0] s1, s2, input logic [4:0] rd);
    @(negedge clk);
    a_in_valid = 1'b1; a_in_op = op; a_in_s1 = s1; a_in_s2 = s2; a_in_rd = rd;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
  endtask

  // lat counts rising edges including the accepting one
  task automatic wait32(output int lat, output bit to);
    lat = 1;
    while (!a_out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    to = !a_out_valid;
  endtask

  task automatic take32;
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    a_out_ready = 1'b0;
  endtask

  task automatic op32(input logic [2:0] op, input logic [31:0] s1, s2, input logic [4:0] rd,
                      output logic [31:0] d, output logic [4:0] ord, output int lat, output bit to);
    start32(op, s1, s2, rd);
    wait32(lat, to);
    d = a_out_d; ord = a_out_rd;
    if (!to) take32();
  endtask

  task automatic op16(input logic [2:0] op, input logic [15:0] s1, s2,
                      output logic [15:0] d, output int lat, output bit to);
    @(negedge clk);
    b_in_valid = 1'b1; b_in_op = op; b_in_s1 = s1; b_in_s2 = s2; b_in_rd = 5'd3;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    lat = 1;
    while (!b_out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    to = !b_out_valid;
    d = b_out_d;
    if (!to) begin
      b_out_ready = 1'b1;
      @(posedge clk); #1;
      b_out_ready = 1'b0;
    end
  endtask

  function automatic logic [15:0] ref16(input logic [2:0] op, input logic [15:0] x, y);
    longint a, b, p;
    bit sx, sy;
    sx = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
    sy = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
    a = sx ? longint'($signed(x)) : longint'(x);
    b = sy ? longint'($signed(y)) : longint'(y);
    if (!op[2]) begin
      p = a * b;
      return (op == 3'd0) ? p[15:0] : p[31:16];
    end
    if (y == 16'h0) return op[1] ? x : 16'hFFFF;
    p = op[1] ? (a % b) : (a / b);
    return p[15:0];
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset;
    #1 reset = 1'b1;
    #1;
    n_cmp++; if (a_out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", a_out_valid); end
    n_cmp++; if (a_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", a_busy); end
    n_cmp++; if (a_out_d !== 32'h0) begin n_bad++; $display("FAIL reset_out_d got %h want 0", a_out_d); end
    n_cmp++; if (a_out_rd !== 5'h0) begin n_bad++; $display("FAIL reset_out_rd got %h want 0", a_out_rd); end
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (a_in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", a_in_ready); end
    n_cmp++; if (b_in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready16 got %b want 1", b_in_ready); end
  endtask

  task automatic test_mul;
    logic [2:0]  ops [5] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd3};
    logic [31:0] s1s [5] = '{32'h7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h7};
    logic [31:0] s2s [5] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFD};
    logic [31:0] exp [5] = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h6};
    logic [31:0] d; logic [4:0] rd; int lat; bit to;
    for (int i = 0; i < 5; i++) begin
      op32(ops[i], s1s[i], s2s[i], 5'(i), d, rd, lat, to);
      n_cmp++; if (to) begin n_bad++; $display("FAIL mul%0d_timeout no out_valid", i); end
      n_cmp++; if (d !== exp[i]) begin n_bad++; $display("FAIL mul%0d_data got %h want %h", i, d, exp[i]); end
      n_cmp++; if (lat !== 34) begin n_bad++; $display("FAIL mul%0d_latency got %0d want 34", i, lat); end
      n_cmp++; if (rd !== 5'(i)) begin n_bad++; $display("FAIL mul%0d_rd got %0d want %0d", i, rd, i); end
    end
  endtask

  task automatic test_div;
    logic [2:0]  ops [5] = '{3'd4, 3'd6, 3'd5, 3'd7, 3'd4};
    logic [31:0] s1s [5] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100, 32'd100};
    logic [31:0] s2s [5] = '{32'd2, 32'd2, 32'd7, 32'd7, 32'hFFFFFFF9};
    logic [31:0] exp [5] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2, 32'hFFFFFFF2};
    logic [31:0] d; logic [4:0] rd; int lat; bit to;
    for (int i = 0; i < 5; i++) begin
      op32(ops[i], s1s[i], s2s[i], 5'd17, d, rd, lat, to);
      n_cmp++; if (to) begin n_bad++; $display("FAIL div%0d_timeout no out_valid", i); end
      n_cmp++; if (d !== exp[i]) begin n_bad++; $display("FAIL div%0d_data got %h want %h", i, d, exp[i]); end
      n_cmp++; if (lat !== 34) begin n_bad++; $display("FAIL div%0d_latency got %0d want 34", i, lat); end
    end
  endtask

  task automatic test_fast_path;
    logic [2:0]  ops [5] = '{3'd4, 3'd6, 3'd4, 3'd6, 3'd7};
    logic [31:0] s1s [5] = '{32'd5, 32'd5, 32'h80000000, 32'h80000000, 32'hABCD};
    logic [31:0] s2s [5] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0};
    logic [31:0] exp [5] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0, 32'hABCD};
    logic [31:0] d; logic [4:0] rd; int lat; bit to;
    for (int i = 0; i < 5; i++) begin
      op32(ops[i], s1s[i], s2s[i], 5'd0, d, rd, lat, to);
      n_cmp++; if (to) begin n_bad++; $display("FAIL fast%0d_timeout no out_valid", i); end
      n_cmp++; if (d !== exp[i]) begin n_bad++; $display("FAIL fast%0d_data got %h want %h", i, d, exp[i]); end
      n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL fast%0d_latency got %0d want 1", i, lat); end
    end
  endtask

  task automatic test_back_to_back;
    int lat; bit to;
    start32(3'd0, 32'd3, 32'd5, 5'd9);
    wait32(lat, to);
    n_cmp++; if (to) begin n_bad++; $display("FAIL hold_timeout no out_valid"); end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (a_out_valid !== 1'b1 || a_out_d !== 32'd15 || a_out_rd !== 5'd9 || a_in_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL hold%0d got v=%b d=%h rd=%0d rdy=%b want v=1 d=f rd=9 rdy=0",
                 i, a_out_valid, a_out_d, a_out_rd, a_in_ready);
      end
    end
    take32();
    n_cmp++; if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
      n_bad++; $display("FAIL handshake_idle got rdy=%b v=%b want rdy=1 v=0", a_in_ready, a_out_valid);
    end
    a_in_valid = 1'b1; a_in_op = 3'd5; a_in_s1 = 32'd100; a_in_s2 = 32'd7; a_in_rd = 5'd4;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    n_cmp++; if (a_busy !== 1'b1 || a_in_ready !== 1'b0) begin
      n_bad++; $display("FAIL next_accept got busy=%b rdy=%b want busy=1 rdy=0", a_busy, a_in_ready);
    end
    wait32(lat, to);
    n_cmp++; if (a_out_d !== 32'd14 || lat !== 34) begin
      n_bad++; $display("FAIL next_result got d=%0d lat=%0d want d=14 lat=34", a_out_d, lat);
    end
    if (!to) take32();
  endtask

  task automatic test_flush;
    int seen;
    start32(3'd0, 32'd9, 32'd9, 5'd2);
    repeat (4) @(posedge clk);
    @(negedge clk) a_flush = 1'b1;
    @(posedge clk); #1;
    a_flush = 1'b0;
    n_cmp++; if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || a_busy !== 1'b0) begin
      n_bad++; $display("FAIL flush_idle got rdy=%b v=%b busy=%b want 1 0 0", a_in_ready, a_out_valid, a_busy);
    end
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (a_out_valid) seen++; end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL flush_no_result got %0d valid cycles want 0", seen); end
  endtask

  task automatic test_async_reset;
    int seen;
    start32(3'd4, 32'd1000, 32'd3, 5'd6);
    repeat (4) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (a_out_valid !== 1'b0 || a_busy !== 1'b0) begin
      n_bad++; $display("FAIL async_reset got v=%b busy=%b want 0 0", a_out_valid, a_busy);
    end
    @(negedge clk) reset = 1'b0;
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (a_out_valid) seen++; end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL reset_no_result got %0d valid cycles want 0", seen); end
  endtask

  task automatic test_xlen16;
    logic [2:0]  ops [10] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd1, 3'd6};
    logic [15:0] s1s [10] = '{16'h7, 16'h8000, 16'hFFFF, 16'hFFFF, 16'hFFF9, 16'hFFF9, 16'd100, 16'd100, 16'h1234, 16'h8765};
    logic [15:0] s2s [10] = '{16'hFFFD, 16'h8000, 16'hFFFF, 16'hFFFF, 16'd2, 16'd2, 16'd7, 16'd7, 16'hF00D, 16'h0123};
    logic [15:0] d, e; int lat; bit to;
    for (int i = 0; i < 10; i++) begin
      op16(ops[i], s1s[i], s2s[i], d, lat, to);
      e = ref16(ops[i], s1s[i], s2s[i]);
      n_cmp++; if (to) begin n_bad++; $display("FAIL x16_%0d_timeout no out_valid", i); end
      n_cmp++; if (d !== e) begin n_bad++; $display("FAIL x16_%0d_data got %h want %h", i, d, e); end
      n_cmp++; if (lat !== 18) begin n_bad++; $display("FAIL x16_%0d_latency got %0d want 18", i, lat); end
    end
  endtask

  initial begin
    reset = 1'b0;
    a_in_valid = 1'b0; a_in_op = '0; a_in_rd = '0; a_in_s1 = '0; a_in_s2 = '0; a_flush = 1'b0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_op = '0; b_in_rd = '0; b_in_s1 = '0; b_in_s2 = '0; b_flush = 1'b0; b_out_ready = 1'b0;
    test_reset();
    test_mul();
    test_div();
    test_fast_path();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_xlen16();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
